// File: rtl/led_reminder.sv
`default_nettype none
// led_reminder -- hourly chime flasher plus alarm LED light show; snooze compiled in with REMINDER_SNOOZE_EN.
// Revision 1.0
module led_reminder #(
  parameter int LED_W      = 14,
  parameter int ALARM_LEN  = 31,
  parameter int ROUNDS     = 1,
  parameter int HOUR12     = 0,
  parameter int SNOOZE_SEC = 60
) (
  input  logic             CP_1Hz,
  input  logic             _CR,
  input  logic             start_light_hour,
  input  logic [7:0]       show_hour,
  input  logic [7:0]       show_sec,
  input  logic             active_alarm,
  input  logic             start_light_alarm,
  input  logic             alarm_stop,
`ifdef REMINDER_SNOOZE_EN
  input  logic             alarm_snooze,
`endif
  output logic [LED_W+1:0] start_light,
  output logic             alarm_busy
);

  localparam int H   = (LED_W + 1) / 2;
  localparam int F_W = $clog2(ALARM_LEN + 1);
  localparam int R_W = $clog2(ROUNDS + 1);
`ifdef REMINDER_SNOOZE_EN
  localparam int T_W = $clog2(SNOOZE_SEC + 1);
`endif
  // An illegal parameter set leaves the alarm permanently idle.
  localparam bit CFG_OK = (LED_W >= 2) && (ALARM_LEN >= 2 * H) && (ROUNDS >= 1) && (SNOOZE_SEC >= 1);

`ifdef REMINDER_SNOOZE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_SNOOZE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_t;
`endif

  state_t           r_state, w_state;
  logic [F_W-1:0]   r_f, w_f;
  logic [R_W-1:0]   r_r, w_r;
  logic             r_trig_prev;
  logic [LED_W-1:0] r_bank, w_bank;
  logic             r_busy, w_busy;
`ifdef REMINDER_SNOOZE_EN
  logic [T_W-1:0]   r_timer, w_timer;
`endif

  logic             r_chime_act, w_chime_act;
  logic [4:0]       r_chime_k, w_chime_k;
  logic [4:0]       r_chime_n, w_chime_n;
  logic [1:0]       r_chime_led, w_chime_led;

  logic [7:0]       w_hr_bin;
  logic [4:0]       w_hr_bin5, w_hr_mod;
  logic             w_hr_valid;
  logic [4:0]       w_hour_n;
  logic             w_kill, w_start;

  function automatic logic [LED_W-1:0] f_pattern(input logic [F_W-1:0] i_frame);
    logic [LED_W-1:0] w_p;
    int fr, k;
    w_p = '0;
    fr  = int'(i_frame);
    k   = (fr < H) ? fr : (2 * H - 2 - fr);
    for (int i = 0; i < LED_W; i++) begin
      if (fr <= 2 * H - 2)
        w_p[i] = (i <= k) || (i >= LED_W - 1 - k);
      else if (fr >= 2 * H)
        w_p[i] = ((i % 2) == ((fr - 2 * H) % 2));
    end
    return w_p;
  endfunction

  always_comb begin
    w_hr_bin   = 8'(show_hour[7:4]) * 8'd10 + 8'(show_hour[3:0]);
    w_hr_valid = (show_hour[3:0] <= 4'd9) && (w_hr_bin <= 8'd23);
    w_hr_bin5  = w_hr_bin[4:0];
    w_hr_mod   = (w_hr_bin5 >= 5'd12) ? (w_hr_bin5 - 5'd12) : w_hr_bin5;
    w_hour_n   = 5'd0;
    if (w_hr_valid) begin
      if (HOUR12 != 0)
        w_hour_n = (w_hr_mod == 5'd0) ? 5'd12 : w_hr_mod;
      else
        w_hour_n = w_hr_bin5;
    end
  end

  always_comb begin
    w_chime_act = r_chime_act;
    w_chime_k   = r_chime_k;
    w_chime_n   = r_chime_n;
    if (!r_chime_act) begin
      if (start_light_hour && (show_sec == 8'h00) && (w_hour_n != 5'd0)) begin
        w_chime_act = 1'b1;
        w_chime_k   = 5'd0;
        w_chime_n   = w_hour_n;
      end
    end else if ((r_chime_k + 5'd1) < r_chime_n) begin
      w_chime_k = r_chime_k + 5'd1;
    end else begin
      w_chime_act = 1'b0;
    end
    w_chime_led = w_chime_act ? (w_chime_k[0] ? 2'b10 : 2'b01) : 2'b00;
  end

  assign w_kill  = alarm_stop || !active_alarm;
  assign w_start = CFG_OK && active_alarm && start_light_alarm && !r_trig_prev;

  always_comb begin
    w_state = r_state;
    w_f     = r_f;
    w_r     = r_r;
`ifdef REMINDER_SNOOZE_EN
    w_timer = r_timer;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_kill && w_start) begin
          w_state = S_RUN;
          w_f     = '0;
          w_r     = R_W'(1);
        end
      end
      S_RUN: begin
        if (w_kill) begin
          w_state = S_IDLE;
`ifdef REMINDER_SNOOZE_EN
        end else if (alarm_snooze) begin
          w_state = S_SNOOZE;
          w_timer = T_W'(SNOOZE_SEC);
`endif
        end else if (r_f == F_W'(ALARM_LEN - 1)) begin
          if (r_r < R_W'(ROUNDS)) begin
            w_f = '0;
            w_r = r_r + 1'b1;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_f = r_f + 1'b1;
        end
      end
`ifdef REMINDER_SNOOZE_EN
      S_SNOOZE: begin
        if (w_kill) begin
          w_state = S_IDLE;
        end else if (r_timer <= T_W'(1)) begin
          w_state = S_RUN;
          w_f     = '0;
          w_r     = R_W'(1);
        end else begin
          w_timer = r_timer - 1'b1;
        end
      end
`endif
      default: w_state = S_IDLE;
    endcase
    w_bank = (w_state == S_RUN) ? f_pattern(w_f) : '0;
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge CP_1Hz or negedge _CR) begin
    if (!_CR) begin
      r_state     <= S_IDLE;
      r_f         <= '0;
      r_r         <= '0;
      r_trig_prev <= 1'b0;
      r_bank      <= '0;
      r_busy      <= 1'b0;
      r_chime_act <= 1'b0;
      r_chime_k   <= 5'd0;
      r_chime_n   <= 5'd0;
      r_chime_led <= 2'b00;
    end else begin
      r_state     <= w_state;
      r_f         <= w_f;
      r_r         <= w_r;
      r_trig_prev <= start_light_alarm;
      r_bank      <= w_bank;
      r_busy      <= w_busy;
      r_chime_act <= w_chime_act;
      r_chime_k   <= w_chime_k;
      r_chime_n   <= w_chime_n;
      r_chime_led <= w_chime_led;
    end
  end

`ifdef REMINDER_SNOOZE_EN
  always_ff @(posedge CP_1Hz or negedge _CR) begin
    if (!_CR) r_timer <= '0;
    else      r_timer <= w_timer;
  end
`endif

  assign start_light = {r_bank, r_chime_led};
  assign alarm_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_reminder.sv
`default_nettype none
// tb_led_reminder -- directed vector table plus hand sequences for led_reminder.
// Revision 1.0
module tb_led_reminder;

  typedef struct {
    logic [7:0]  hour;
    logic [7:0]  sec;
    logic        en, arm, trg, stp;
    logic [15:0] led;
    logic        busy;
  } vec_t;

  logic        clk, rst_n;
  logic        en, h12_en, armed, trig, r2_trig, stop, tie0;
  logic [7:0]  hour, sec;
  logic [15:0] led, r2_led, h12_led;
  logic        busy, r2_busy, h12_busy;
`ifdef REMINDER_SNOOZE_EN
  logic        snooze;
`endif

  vec_t        vecs[$];
  logic [13:0] frm [31];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          cnt;

  led_reminder #(.SNOOZE_SEC(3)) u_dut (
    .CP_1Hz(clk), ._CR(rst_n), .start_light_hour(en), .show_hour(hour), .show_sec(sec),
    .active_alarm(armed), .start_light_alarm(trig), .alarm_stop(stop),
`ifdef REMINDER_SNOOZE_EN
    .alarm_snooze(snooze),
`endif
    .start_light(led), .alarm_busy(busy));

  led_reminder #(.ROUNDS(2)) u_r2 (
    .CP_1Hz(clk), ._CR(rst_n), .start_light_hour(tie0), .show_hour(hour), .show_sec(sec),
    .active_alarm(armed), .start_light_alarm(r2_trig), .alarm_stop(stop),
`ifdef REMINDER_SNOOZE_EN
    .alarm_snooze(tie0),
`endif
    .start_light(r2_led), .alarm_busy(r2_busy));

  led_reminder #(.HOUR12(1)) u_h12 (
    .CP_1Hz(clk), ._CR(rst_n), .start_light_hour(h12_en), .show_hour(hour), .show_sec(sec),
    .active_alarm(tie0), .start_light_alarm(tie0), .alarm_stop(tie0),
`ifdef REMINDER_SNOOZE_EN
    .alarm_snooze(tie0),
`endif
    .start_light(h12_led), .alarm_busy(h12_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] h, input logic [7:0] s, input logic e, input logic a,
                     input logic t, input logic p, input logic [15:0] l, input logic b);
    vec_t v;
    v.hour = h; v.sec = s; v.en = e; v.arm = a; v.trg = t; v.stp = p; v.led = l; v.busy = b;
    vecs.push_back(v);
  endtask

  initial begin
    frm = '{14'h2001, 14'h3003, 14'h3807, 14'h3C0F, 14'h3E1F, 14'h3F3F, 14'h3FFF, 14'h3F3F,
            14'h3E1F, 14'h3C0F, 14'h3807, 14'h3003, 14'h2001, 14'h0000,
            14'h1555, 14'h2AAA, 14'h1555, 14'h2AAA, 14'h1555, 14'h2AAA, 14'h1555, 14'h2AAA,
            14'h1555, 14'h2AAA, 14'h1555, 14'h2AAA, 14'h1555, 14'h2AAA, 14'h1555, 14'h2AAA,
            14'h1555};

    // chime: 3 flashes (retrigger ignored), then hours that must not chime
    add(8'h03, 8'h00, 1, 0, 0, 0, 16'h0001, 0);
    add(8'h03, 8'h00, 1, 0, 0, 0, 16'h0002, 0);
    add(8'h03, 8'h02, 1, 0, 0, 0, 16'h0001, 0);
    add(8'h03, 8'h03, 1, 0, 0, 0, 16'h0000, 0);
    add(8'h00, 8'h00, 1, 0, 0, 0, 16'h0000, 0);
    add(8'h00, 8'h01, 1, 0, 0, 0, 16'h0000, 0);
    add(8'h0A, 8'h00, 1, 0, 0, 0, 16'h0000, 0);
    add(8'h24, 8'h00, 1, 0, 0, 0, 16'h0000, 0);
    add(8'h23, 8'h05, 1, 0, 0, 0, 16'h0000, 0);
    add(8'h01, 8'h00, 0, 0, 0, 0, 16'h0000, 0);
    // full alarm round with trigger held, then no restart
    for (int i = 0; i < 31; i++) add(8'h00, 8'h30, 0, 1, 1, 0, {frm[i], 2'b00}, 1);
    add(8'h00, 8'h30, 0, 1, 1, 0, 16'h0000, 0);
    add(8'h00, 8'h30, 0, 1, 1, 0, 16'h0000, 0);
    add(8'h00, 8'h30, 0, 1, 0, 0, 16'h0000, 0);
    // restart, chime of 5 overlapping, stop at frame 5
    add(8'h00, 8'h30, 0, 1, 1, 0, {frm[0], 2'b00}, 1);
    add(8'h00, 8'h30, 0, 1, 1, 0, {frm[1], 2'b00}, 1);
    add(8'h00, 8'h30, 0, 1, 1, 0, {frm[2], 2'b00}, 1);
    add(8'h05, 8'h00, 1, 1, 1, 0, {frm[3], 2'b01}, 1);
    add(8'h05, 8'h01, 1, 1, 1, 0, {frm[4], 2'b10}, 1);
    add(8'h05, 8'h02, 1, 1, 1, 0, {frm[5], 2'b01}, 1);
    add(8'h05, 8'h03, 1, 1, 1, 1, 16'h0002, 0);
    add(8'h05, 8'h04, 1, 1, 1, 0, 16'h0001, 0);
    add(8'h05, 8'h05, 1, 1, 1, 0, 16'h0000, 0);
    // stop and disarm beat a coincident start; disarm mid-run
    add(8'h00, 8'h30, 0, 1, 0, 0, 16'h0000, 0);
    add(8'h00, 8'h30, 0, 1, 1, 1, 16'h0000, 0);
    add(8'h00, 8'h30, 0, 1, 1, 0, 16'h0000, 0);
    add(8'h00, 8'h30, 0, 1, 0, 0, 16'h0000, 0);
    add(8'h00, 8'h30, 0, 0, 1, 0, 16'h0000, 0);
    add(8'h00, 8'h30, 0, 1, 0, 0, 16'h0000, 0);
    add(8'h00, 8'h30, 0, 1, 1, 0, {frm[0], 2'b00}, 1);
    add(8'h00, 8'h30, 0, 0, 1, 0, 16'h0000, 0);

    rst_n = 1'b0; tie0 = 1'b0;
    en = 0; h12_en = 0; armed = 0; trig = 0; r2_trig = 0; stop = 0;
    hour = 8'h00; sec = 8'h00;
`ifdef REMINDER_SNOOZE_EN
    snooze = 0;
`endif
    #12;
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_r2", 32'({r2_busy, r2_led}), 32'd0);
    tick;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      hour = vecs[i].hour; sec = vecs[i].sec; en = vecs[i].en;
      armed = vecs[i].arm; trig = vecs[i].trg; stop = vecs[i].stp;
      tick;
      chk($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].led));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // 12-hour chime: 13h -> one flash, 0h -> twelve flashes
    en = 0; trig = 0; h12_en = 1; hour = 8'h13; sec = 8'h00;
    tick; chk("h12_13_first", 32'(h12_led), 32'h1);
    sec = 8'h01;
    tick; chk("h12_13_done", 32'(h12_led), 32'h0);
    hour = 8'h00; sec = 8'h00;
    tick; sec = 8'h01;
    cnt = 0;
    while (h12_led[1:0] != 2'b00 && cnt < 20) begin
      cnt++;
      tick;
    end
    chk("h12_00_flashes", 32'(cnt), 32'd12);
    chk("h12_busy", 32'(h12_busy), 32'd0);
    h12_en = 0;

    // two rounds, trigger held throughout
    armed = 1; r2_trig = 0;
    tick; r2_trig = 1;
    for (int i = 0; i < 62; i++) begin
      tick;
      chk($sformatf("r2_frame%0d", i), 32'({r2_busy, r2_led}), 32'({1'b1, frm[i % 31], 2'b00}));
    end
    tick; chk("r2_end", 32'({r2_busy, r2_led}), 32'd0);
    tick; chk("r2_no_restart", 32'({r2_busy, r2_led}), 32'd0);
    r2_trig = 0;
    tick; r2_trig = 1;
    tick; chk("r2_restart", 32'({r2_busy, r2_led}), 32'({1'b1, frm[0], 2'b00}));
    r2_trig = 0;

    // asynchronous reset mid-alarm and mid-chime
    trig = 0;
    tick; trig = 1; hour = 8'h05; sec = 8'h00; en = 1;
    tick; sec = 8'h01;
    tick;
    tick; chk("pre_rst_led", 32'(led), 32'({frm[2], 2'b01}));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_r2", 32'({r2_busy, r2_led}), 32'd0);
    trig = 0; en = 0; sec = 8'h10;
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("post_rst%0d", i), 32'({busy, led}), 32'd0);
    end

`ifdef REMINDER_SNOOZE_EN
    trig = 0;
    tick; trig = 1;
    tick; chk("sn_f0", 32'({busy, led}), 32'({1'b1, frm[0], 2'b00}));
    tick; tick; tick; tick;
    chk("sn_f4", 32'({busy, led}), 32'({1'b1, frm[4], 2'b00}));
    snooze = 1;
    tick; chk("sn_s1", 32'({busy, led}), 32'h10000);
    snooze = 0;
    tick; chk("sn_s2", 32'({busy, led}), 32'h10000);
    tick; chk("sn_s3", 32'({busy, led}), 32'h10000);
    tick; chk("sn_resume_f0", 32'({busy, led}), 32'({1'b1, frm[0], 2'b00}));
    tick; chk("sn_resume_f1", 32'({busy, led}), 32'({1'b1, frm[1], 2'b00}));
    snooze = 1;
    tick; chk("sn_again", 32'({busy, led}), 32'h10000);
    snooze = 0; stop = 1;
    tick; chk("sn_stop", 32'({busy, led}), 32'd0);
    stop = 0;
    tick; chk("sn_idle", 32'({busy, led}), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_reminder.md
# led_reminder

Parametrised LED reminder for the digital clock: flashes the hour count on a two-LED chime pair at the top of each hour and plays a configurable light show on an alarm LED bank when the alarm fires. It sits beside the time/alarm counters and takes their BCD time and alarm-match outputs. Its output drives the board LED bank directly. Over the first-generation block it adds:
- arithmetic patterns of any width
- edge-triggered alarm start
- multi-round playback
- stop control
- 12-hour chime mode
- optional snooze

## Interface
- LED_W, 14, number of alarm LEDs (≥2)
- ALARM_LEN, 31, frames per alarm round; must be ≥ 2·H, where H = ceil(LED_W/2)
- ROUNDS, 1, number of back-to-back alarm rounds (≥1)
- HOUR12, 0, 1 = chime count uses 12-hour convention
- SNOOZE_SEC, 60, snooze length in seconds (≥1; used only with snooze compiled in)

- CP_1Hz  in  1  1 Hz clock, all state on rising edge
- _CR  in  1  asynchronous active-low reset
- start_light_hour  in  1  hourly chime enable
- show_hour  in  8  current hour, BCD
- show_sec  in  8  current second, BCD
- active_alarm  in  1  alarm armed; low forces the alarm idle
- start_light_alarm  in  1  alarm-match level; start on its rising edge
- alarm_stop  in  1  active-high cancel
- alarm_snooze  in  1  active-high snooze request; port exists only with REMINDER_SNOOZE_EN
- start_light  out  LED_W+2  [1:0] chime pair, [LED_W+1:2] alarm bank
- alarm_busy  out  1  high in RUN or SNOOZE

## Operation
- **Reset.** All outputs, counters, states and the trigger history register are 0.
- **Chime path.** Independent of the alarm path.
  - Trigger: chime idle, start_light_hour=1, show_sec=8'h00.
  - Loaded count N = binary of show_hour.
  - Invalid BCD (any digit >9, or value >23) gives N=0.
  - With HOUR12=1: N = hour mod 12, and hour 0 or 12 gives 12.
  - N=0: no chime.
  - Flash k (k=0..N-1) drives [1:0]=2'b01 for even k and 2'b10 for odd k; after flash N-1, [1:0]=00.
  - Triggers while active are ignored.
- **Alarm FSM.** States IDLE, RUN and SNOOZE (SNOOZE only with the macro). Registers: frame counter f, round counter r.
  - IDLE→RUN: active_alarm=1, start_light_alarm=1, and previous-cycle start_light_alarm=0; loads f=0, r=1.
  - RUN: each edge f++. After f=ALARM_LEN-1: if r<ROUNDS then f=0, r++; else IDLE.
  - Any state→IDLE when alarm_stop=1 or active_alarm=0. This has priority over start and snooze; the bank goes to 0.
- **Alarm bank pattern** for frame f (bit i, 0..LED_W-1):
  - f<H: bit i on iff i≤f or i≥LED_W-1-f (fill from both edges).
  - H≤f≤2H-2: with k=2H-2-f, bit i on iff i≤k or i≥LED_W-1-k (drain).
  - f=2H-1: all off.
  - f≥2H: if (f-2H) is even, even-indexed bits on; else odd-indexed bits on.
- The bank is 0 in IDLE and SNOOZE.

## Timing
- Outputs are registered.
- Chime triggered at edge E0: 01 after E0, 10 after E1, and so on. [1:0]=00 after edge E_N.
- Alarm start detected at edge E: frame 0 is shown after E. One frame per second.
- Total alarm duration: ALARM_LEN·ROUNDS seconds. Bank is 0 and alarm_busy=0 after the following edge.
- Stop or disarm at edge E: bank 0 and busy 0 after E. A start condition at the same edge is ignored.
- A trigger held high through completion does not restart the alarm; it needs a new rising edge.
- Chime and alarm run concurrently and do not interact.
- _CR low mid-operation: everything clears immediately. Activity resumes only on a fresh trigger after release.

## Configuration
- REMINDER_SNOOZE_EN defined:
  - alarm_snooze port and SNOOZE state exist.
  - RUN with snooze=1 → SNOOZE: bank 0, timer loaded with SNOOZE_SEC.
  - The timer decrements each edge. At 0 → RUN with f=0, r=1.
  - Stop or disarm in SNOOZE → IDLE.
- REMINDER_SNOOZE_EN undefined: no port, no SNOOZE state, no timer logic.

## Test plan
- Chime, defaults: hour 8'h03, sec 8'h00, enable=1 → [1:0] sequence 01, 10, 01, 00. Hour 8'h00 → stays 00. HOUR12=1 with 8'h13 → one flash 01.
- Alarm, defaults: rising start with armed=1 →
  - frame 0 = 14'h2001
  - frame 6 = 14'h3FFF
  - frame 7 = 14'h3F3F
  - frame 13 = 0
  - frame 14 = 14'h1555
  - frame 15 = 14'h2AAA
  - frame 30 = 14'h1555
  - then 0 and busy=0 at second 31
- ROUNDS=2 with the trigger held high → 62 frames, then idle with no restart. A new rising edge restarts at frame 0.
- alarm_stop pulsed at frame 5, coincident with a chime → bank 0 on the next edge while the chime continues unaffected.
- _CR asserted mid-alarm and mid-chime → all outputs 0 asynchronously. No resumption after release.
- REMINDER_SNOOZE_EN, SNOOZE_SEC=3: snooze at frame 4 → bank 0 for 3 s, then frame 0 = 14'h2001. Stop during snooze → IDLE.
